// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types, register map and width helpers for the SECDED APB engine
package ecc_pkg;

    localparam int CW_MAX = 32;

    typedef enum logic [1:0] {
        MODE_ENC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_FULL = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        CW8  = 2'd0,
        CW16 = 2'd1,
        CW32 = 2'd2
    } width_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC1,
        S_CALC2,
        S_DONE
    } state_t;

    // Byte offsets; only PADDR[4:2] takes part in decode.
    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_DATA_IN  = 5'h04;
    localparam logic [4:0] REG_CW_WIDTH = 5'h08;
    localparam logic [4:0] REG_NOISE    = 5'h0C;
    localparam logic [4:0] REG_STATUS   = 5'h10;

    function automatic int n_of(width_t w);
        case (w)
            CW8:     return 8;
            CW16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int k_of(width_t w);
        case (w)
            CW8:     return 4;
            CW16:    return 11;
            default: return 26;
        endcase
    endfunction

    function automatic logic is_pow2(int x);
        return (x & (x - 1)) == 0;
    endfunction

endpackage

// File: rtl/ecc_apb_engine_if.sv
// rtl/ecc_apb_engine_if.sv - APB3 bus bundle between the stimulus master and the ECC engine
// Signals: PADDR, PWDATA, PSEL, PENABLE, PWRITE (master -> slave); PRDATA, PREADY, PSLVERR (slave -> master).
interface ecc_apb_engine_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) ();
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ecc_secded_core.sv
// rtl/ecc_secded_core.sv - combinational extended-Hamming encoder and decoder for 8/16/32-bit codewords
// Ports: width (codeword size select); enc_data -> enc_cw (encode path);
//        dec_cw -> dec_data, dec_nerr (decode path: 0 none, 1 corrected, 2 double detected).
module ecc_secded_core
    import ecc_pkg::*;
(
    input  width_t            width,
    input  logic [CW_MAX-1:0] enc_data,
    output logic [CW_MAX-1:0] enc_cw,
    input  logic [CW_MAX-1:0] dec_cw,
    output logic [CW_MAX-1:0] dec_data,
    output logic [1:0]        dec_nerr
);
    int                n_bits;
    logic [CW_MAX-1:0] data_k;
    logic [CW_MAX-1:0] placed;
    logic [CW_MAX-1:0] cw;
    logic [CW_MAX-1:0] fixed;
    logic [CW_MAX-1:0] mask;
    logic [4:0]        enc_j;
    logic [4:0]        enc_s;
    logic [4:0]        dec_j;
    logic [4:0]        dec_s;
    logic              ovr;
    logic              dec_p;

    assign n_bits = n_of(width);
    assign data_k = enc_data & ((32'h1 << k_of(width)) - 32'h1);
    assign mask   = (n_bits == 32) ? '1 : ((32'h1 << n_bits) - 32'h1);

    // Bit i holds Hamming position i+1; the top bit (n-1) is overall parity.
    always_comb begin
        placed = '0;
        enc_j  = '0;
        for (int i = 0; i < CW_MAX - 1; i++) begin
            if (i + 1 < n_bits && !is_pow2(i + 1)) begin
                placed[i] = data_k[enc_j];
                enc_j     = enc_j + 5'd1;
            end
        end
        // Syndrome of the data-only word gives every parity bit at once.
        enc_s = '0;
        for (int i = 0; i < CW_MAX - 1; i++) begin
            if (placed[i]) enc_s = enc_s ^ 5'(i + 1);
        end
        enc_cw = placed;
        for (int i = 0; i < CW_MAX - 1; i++) begin
            if (i + 1 < n_bits && is_pow2(i + 1)) enc_cw[i] = |(enc_s & 5'(i + 1));
        end
        ovr = ^enc_cw;
        for (int i = 0; i < CW_MAX; i++) begin
            if (i == n_bits - 1) enc_cw[i] = ovr;
        end
    end

    always_comb begin
        cw    = dec_cw & mask;
        dec_p = ^cw;
        dec_s = '0;
        for (int i = 0; i < CW_MAX - 1; i++) begin
            if (i + 1 < n_bits && cw[i]) dec_s = dec_s ^ 5'(i + 1);
        end
        // Odd overall parity means a single error; syndrome 0 points at the overall bit.
        fixed = cw;
        for (int i = 0; i < CW_MAX; i++) begin
            if (dec_p && ((dec_s == 5'd0 && i == n_bits - 1) ||
                          (dec_s != 5'd0 && 5'(i + 1) == dec_s)))
                fixed[i] = ~fixed[i];
        end
        if (dec_p)                dec_nerr = 2'd1;
        else if (dec_s != 5'd0)   dec_nerr = 2'd2;
        else                      dec_nerr = 2'd0;
        dec_data = '0;
        dec_j    = '0;
        for (int i = 0; i < CW_MAX - 1; i++) begin
            if (i + 1 < n_bits && !is_pow2(i + 1)) begin
                dec_data[dec_j] = fixed[i];
                dec_j           = dec_j + 5'd1;
            end
        end
    end
endmodule

// File: rtl/ecc_apb_engine.sv
// rtl/ecc_apb_engine.sv - APB3 slave SECDED engine: register file, busy FSM and result outputs
// Ports: clk, rst (sync active-high); apb (slave modport of ecc_apb_engine_if);
//        data_out (zero-extended result), operation_done (1-cycle pulse), num_of_errors (0/1/2).
module ecc_apb_engine
    import ecc_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_apb_engine_if.slave       apb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done,
    output logic [1:0]            num_of_errors
);
    state_t            state, state_nxt;
    logic [1:0]        ctrl_reg;
    logic [1:0]        cw_width_reg;
    logic [CW_MAX-1:0] data_in_reg;
    logic [CW_MAX-1:0] noise_reg;
    logic [CW_MAX-1:0] cw_work;
    logic [CW_MAX-1:0] enc_cw;
    logic [CW_MAX-1:0] dec_cw;
    logic [CW_MAX-1:0] dec_data;
    logic [1:0]        dec_nerr;
    logic [CW_MAX-1:0] rdata;
    logic [4:0]        off;
    logic              access, busy, apb_err, wr_ok, ctrl_start;
    mode_t             mode;
    logic              unused_addr;

    assign off         = {apb.PADDR[4:2], 2'b00};
    assign unused_addr = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5], apb.PADDR[1:0]};
    assign access      = apb.PSEL && apb.PENABLE;
    assign busy        = (state != S_IDLE);
    assign mode        = mode_t'(ctrl_reg);

    always_comb begin
        apb_err = 1'b0;
        if (off > REG_STATUS)
            apb_err = 1'b1;
        else if (apb.PWRITE) begin
            if (busy || off == REG_STATUS)
                apb_err = 1'b1;
            else if ((off == REG_CTRL || off == REG_CW_WIDTH) && apb.PWDATA[1:0] == 2'b11)
                apb_err = 1'b1;
        end
    end

    assign wr_ok      = access && apb.PWRITE && !apb_err;
    assign ctrl_start = wr_ok && (off == REG_CTRL);

    always_comb begin
        rdata = '0;
        case (off)
            REG_CTRL:     rdata = {30'd0, ctrl_reg};
            REG_DATA_IN:  rdata = data_in_reg;
            REG_CW_WIDTH: rdata = {30'd0, cw_width_reg};
            REG_NOISE:    rdata = noise_reg;
            REG_STATUS:   rdata = {29'd0, num_of_errors, busy};
            default:      rdata = '0;
        endcase
    end

    assign apb.PRDATA  = (access && !apb.PWRITE && !apb_err && !rst) ? AMBA_WORD'(rdata) : '0;
    assign apb.PSLVERR = access && apb_err && !rst;
    assign apb.PREADY  = 1'b1;

    // Writes are refused while busy, so these registers stay frozen for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg     <= '0;
            cw_width_reg <= '0;
            data_in_reg  <= '0;
            noise_reg    <= '0;
        end else if (wr_ok) begin
            case (off)
                REG_CTRL:     ctrl_reg     <= apb.PWDATA[1:0];
                REG_DATA_IN:  data_in_reg  <= apb.PWDATA[CW_MAX-1:0];
                REG_CW_WIDTH: cw_width_reg <= apb.PWDATA[1:0];
                REG_NOISE:    noise_reg    <= apb.PWDATA[CW_MAX-1:0];
                default:      ;
            endcase
        end
    end

    // CALC2 decodes the noisy word built in CALC1; plain decode uses DATA_IN directly.
    assign dec_cw = (state == S_CALC2) ? cw_work : data_in_reg;

    ecc_secded_core u_core (
        .width    (width_t'(cw_width_reg)),
        .enc_data (data_in_reg),
        .enc_cw   (enc_cw),
        .dec_cw   (dec_cw),
        .dec_data (dec_data),
        .dec_nerr (dec_nerr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        operation_done = 1'b0;
        case (state)
            S_IDLE:  if (ctrl_start) state_nxt = S_CALC1;
            S_CALC1: state_nxt = (mode == MODE_FULL) ? S_CALC2 : S_DONE;
            S_CALC2: state_nxt = S_DONE;
            S_DONE: begin
                operation_done = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results land on the edge into DONE so they are valid while operation_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out      <= '0;
            num_of_errors <= '0;
            cw_work       <= '0;
        end else begin
            case (state)
                S_CALC1: begin
                    if (mode == MODE_FULL)
                        cw_work <= enc_cw ^ noise_reg;
                    else if (mode == MODE_ENC) begin
                        data_out      <= DATA_WIDTH'(enc_cw);
                        num_of_errors <= 2'd0;
                    end else begin
                        data_out      <= DATA_WIDTH'(dec_data);
                        num_of_errors <= dec_nerr;
                    end
                end
                S_CALC2: begin
                    data_out      <= DATA_WIDTH'(dec_data);
                    num_of_errors <= dec_nerr;
                end
                default: ;
            endcase
        end
    end
endmodule
